// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace buffer: widths, entry layout
// and the saturating counter helper.
package trace_pkg;

    localparam int PC_WIDTH_DEF = 64;
    localparam int INSTR_WIDTH  = 32;
    localparam int CNT_WIDTH    = 32;

    // Entry layout, LSB first: {gap, pc, instr}
    localparam int INSTR_LSB = 0;
    localparam int PC_LSB    = INSTR_LSB + INSTR_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Position of the gap flag, just above the pc field.
    function automatic int gap_bit(input int pc_width);
        return PC_LSB + pc_width;
    endfunction

    // Total stored entry width including the gap flag.
    function automatic int entry_width(input int pc_width);
        return pc_width + INSTR_WIDTH + 1;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered head-of-queue output. The head register
// is loaded with whatever entry will sit at the read pointer after the edge,
// so a write into an empty FIFO appears one cycle later with no bypass.
module trace_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [AW:0]      count;
    logic [AW:0]      count_n;
    logic             pop;

    assign pop   = rd_en && valid;
    assign level = count;

    // Next read pointer and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_ptr_n = rd_ptr;
        count_n  = count;
        if (pop) begin
            rd_ptr_n = rd_ptr + AW'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_n = count + (AW+1)'(1);
            2'b01:   count_n = count - (AW+1)'(1);
            default: count_n = count;
        endcase
    end

    // Storage array write port.
    // NOTE: the data array has no reset; validity is tracked by count/valid, so
    // clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer, occupancy and valid registers.
    // NOTE: all sequential state uses non-blocking assignment so every register
    // sees pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            valid  <= (count_n != '0);
        end
    end

    // Head register: the entry that will sit at the read pointer after this
    // edge, taking a same-edge write into that slot into account.
    always_ff @(posedge clk) begin
        rd_data <= (wr_en && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
    end

endmodule

// File: rtl/trace_buffer.sv
// Control-flow trace buffer: keeps unfiltered retired instructions in a FIFO,
// marks entries that follow lost ones, and counts filtered and lost events.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            instr_valid,
    input  logic [PC_WIDTH-1:0]             pc,
    input  logic [INSTR_WIDTH-1:0]          instr,
    input  logic                            drop_instr,
    input  logic                            clear_counters,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [PC_WIDTH+INSTR_WIDTH-1:0] m_tdata,
    output logic                            m_tuser,
    output logic [$clog2(DEPTH):0]          fill_level,
    output logic [CNT_WIDTH-1:0]            drop_count,
    output logic [CNT_WIDTH-1:0]            overflow_count
);

    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int EW      = entry_width(PC_WIDTH);
    localparam int GAP_BIT = gap_bit(PC_WIDTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic                 kept;
    logic                 filtered;
    logic                 pop;
    logic                 accept;
    logic                 lost;
    logic                 gap_q;
    logic [CNT_WIDTH-1:0] drop_q;
    logic [CNT_WIDTH-1:0] ovf_q;
    logic [EW-1:0]        wr_entry;
    logic [EW-1:0]        head;

    assign kept     = instr_valid && !drop_instr;
    assign filtered = instr_valid &&  drop_instr;
    assign pop      = m_tvalid && m_tready;
    // A full buffer still takes the event if the head leaves on the same edge.
    assign accept   = kept && ((fill_level != FULL_LEVEL) || pop);
    assign lost     = kept && !accept;
    assign wr_entry = {gap_q, pc, instr};

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (wr_entry),
        .rd_en   (m_tready),
        .rd_data (head),
        .valid   (m_tvalid),
        .level   (fill_level)
    );

    assign m_tdata        = head[PC_LSB+PC_WIDTH-1:INSTR_LSB];
    assign m_tuser        = head[GAP_BIT];
    assign drop_count     = drop_q;
    assign overflow_count = ovf_q;

    // Gap flag plus saturating statistics; a clear beats any same-edge count.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q  <= 1'b0;
            drop_q <= '0;
            ovf_q  <= '0;
        end else begin
            if (lost) begin
                gap_q <= 1'b1;
            end else if (accept) begin
                gap_q <= 1'b0;
            end
            if (clear_counters) begin
                drop_q <= '0;
                ovf_q  <= '0;
            end else begin
                if (filtered) drop_q <= sat_inc(drop_q);
                if (lost)     ovf_q  <= sat_inc(ovf_q);
            end
        end
    end

endmodule
